training_feeder: RTL

TRAINING_FEEDER -- requirements
Module: training_feeder

---
 rtl/training_feeder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/training_feeder.sv
// Training-case feeder.
// Stores CASES (activation, ideal-output) pairs and streams them to a DNN one chunk per cycle.
// Each case is NCH chunk cycles (LSB chunk first) followed by GAP idle cycles, so a case
// occupies NCH+GAP cycles. Case order is either sequential or taken from a 16-bit Fibonacci
// LFSR. All outputs are registered.
module training_feeder #(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned N_OUT = 4,
  parameter int unsigned ACT_W = 4,
  parameter int unsigned Y_W   = 1,
  parameter int unsigned CASES = 8,
  parameter int unsigned GAP   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(CASES)-1:0] wr_addr,
  input  logic [N_IN-1:0]          wr_act,
  input  logic [N_OUT-1:0]         wr_y,
  input  logic                     run,
  input  logic                     rand_mode,
  output logic [ACT_W-1:0]         act_in,
  output logic [Y_W-1:0]           y_in,
  output logic                     feed_valid,
  output logic                     case_start,
  output logic [$clog2(CASES)-1:0] case_idx,
  output logic [15:0]              case_count,
  output logic                     busy
);

  localparam int unsigned AW  = $clog2(CASES);
  localparam int unsigned NCH = N_IN / ACT_W;
  localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned GW  = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] ChLast  = CW'(NCH - 1);
  localparam logic [GW-1:0] GapLast = GW'((GAP > 0) ? GAP - 1 : 0);

  // Both patterns must split into the same number of chunks, with no remainder.
  if ((NCH * ACT_W != N_IN) || (NCH * Y_W != N_OUT)) begin : g_bad_chunking
    $error("training_feeder: N_IN/ACT_W must equal N_OUT/Y_W with no remainder");
  end

  // Case index is taken from the LFSR low bits, so CASES must be a power of two <= 2^16.
  if ((CASES < 2) || (CASES > 65536) || ((CASES & (CASES - 1)) != 0)) begin : g_bad_cases
    $error("training_feeder: CASES must be a power of two between 2 and 65536");
  end

  typedef enum logic [1:0] {StIdle, StFeed, StGap} state_e;

  state_e                state_q;
  logic [N_IN+N_OUT-1:0] mem_q [CASES];
  logic [N_IN-1:0]       act_sr_q;
  logic [N_OUT-1:0]      y_sr_q;
  logic [CW-1:0]         chunk_q;
  logic [GW-1:0]         gap_q;
  logic [15:0]           lfsr_q;
  logic [AW-1:0]         next_seq_q;

  logic [15:0]           lfsr_adv;
  logic [AW-1:0]         sel;
  logic [N_IN+N_OUT-1:0] sel_word;
  logic                  feed_last;
  logic                  gap_last;
  logic                  decide;
  logic                  launch;
  logic                  stop;

  // Case memory: plain flops, writable in any state and never cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {wr_y, wr_act};
    end
  end

  // Case selection and the points where run is sampled.
  always_comb begin
    // Right-shift Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1.
    lfsr_adv  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    sel       = rand_mode ? lfsr_adv[AW-1:0] : next_seq_q;
    // Combinational read of the current contents: a same-edge write is not seen.
    sel_word  = mem_q[sel];
    feed_last = (state_q == StFeed) && (chunk_q == ChLast);
    gap_last  = (state_q == StGap) && (gap_q == GapLast);
    // run only matters in IDLE and on the final cycle of a case (end of gap).
    decide    = (state_q == StIdle) || gap_last || (feed_last && (GAP == 0));
    launch    = decide && run;
    stop      = decide && !run && (state_q != StIdle);
  end

  // Feeder FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      act_sr_q   <= '0;
      y_sr_q     <= '0;
      chunk_q    <= '0;
      gap_q      <= '0;
      lfsr_q     <= 16'hACE1;
      next_seq_q <= '0;
      act_in     <= '0;
      y_in       <= '0;
      feed_valid <= 1'b0;
      case_start <= 1'b0;
      case_idx   <= '0;
      case_count <= '0;
      busy       <= 1'b0;
    end else if (launch) begin
      // Latch the whole case and present chunk 0 in the first FEED cycle.
      state_q    <= StFeed;
      chunk_q    <= '0;
      gap_q      <= '0;
      act_sr_q   <= sel_word[N_IN-1:0] >> ACT_W;
      y_sr_q     <= sel_word[N_IN+N_OUT-1:N_IN] >> Y_W;
      act_in     <= sel_word[ACT_W-1:0];
      y_in       <= sel_word[N_IN+Y_W-1:N_IN];
      feed_valid <= 1'b1;
      case_start <= 1'b1;
      busy       <= 1'b1;
      case_idx   <= sel;
      next_seq_q <= sel + 1'b1;
      if (rand_mode) begin
        lfsr_q <= lfsr_adv;
      end
      if (case_count != 16'hFFFF) begin
        case_count <= case_count + 16'd1;
      end
    end else if (stop) begin
      state_q    <= StIdle;
      chunk_q    <= '0;
      gap_q      <= '0;
      act_in     <= '0;
      y_in       <= '0;
      feed_valid <= 1'b0;
      case_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case_start <= 1'b0;
      unique case (state_q)
        StIdle: ;
        StFeed: begin
          if (chunk_q == ChLast) begin
            // Only reached with GAP > 0; GAP == 0 ends the case through decide.
            state_q    <= StGap;
            chunk_q    <= '0;
            gap_q      <= '0;
            act_in     <= '0;
            y_in       <= '0;
            feed_valid <= 1'b0;
          end else begin
            chunk_q  <= chunk_q + 1'b1;
            act_in   <= act_sr_q[ACT_W-1:0];
            y_in     <= y_sr_q[Y_W-1:0];
            act_sr_q <= act_sr_q >> ACT_W;
            y_sr_q   <= y_sr_q >> Y_W;
          end
        end
        StGap: begin
          gap_q <= gap_q + 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
